// File: rtl/uart_tx_arbiter_if.sv
// Byte-producer request bus for uart_tx_arbiter.
// Producers drive valid/last/data; the arbiter answers with a one-hot ready pulse.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_last;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;

    modport master (
        output req_valid,
        output req_last,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_last,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one uart_tx_8n1 among N_REQ producers.
// Multi-byte messages keep the grant locked to one owner until its last byte.
module uart_tx_arbiter #(
    parameter int              N_REQ      = 4,
    parameter int              GAP_CYCLES = 2,
    parameter int              TO_W       = 16,
    parameter logic [TO_W-1:0] TIMEOUT    = 16'd40000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_tx_arbiter_if.slave     req,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic [7:0]           tx_txbyte,
    output logic                 tx_senddata,
    input  logic                 tx_txdone,
    output logic                 timeout_err
);

    localparam int PW = $clog2(N_REQ);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TO_W-1:0] TO_LAST =
        (TIMEOUT > 0) ? TIMEOUT - TO_W'(1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rr_q, rr_d;
    logic              lock_q, lock_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [7:0]        byte_q, byte_d;
    logic [N_REQ-1:0]  ready_q, ready_d;
    logic              terr_q, terr_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [TO_W-1:0]   to_q, to_d;

    logic              win_found;
    logic [PW-1:0]     win_idx;
    logic [N_REQ-1:0]  win_oh;
    logic [PW-1:0]     scan_idx;
    logic [TO_W-1:0]   to_inc;
    logic              to_hit;

    // Scan downward so the requester nearest after rr_q is the last write.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_q;
        scan_idx  = '0;
        if (lock_q) begin
            win_found = req.req_valid[rr_q];
        end else begin
            for (int k = N_REQ; k >= 1; k--) begin
                scan_idx = PW'((int'(rr_q) + k) % N_REQ);
                if (req.req_valid[scan_idx]) begin
                    win_found = 1'b1;
                    win_idx   = scan_idx;
                end
            end
        end
        win_oh = N_REQ'(1) << win_idx;
    end

    assign to_inc = (to_q == '1) ? to_q : to_q + TO_W'(1);
    assign to_hit = (to_q >= TO_LAST);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        lock_d  = lock_q;
        grant_d = grant_q;
        byte_d  = byte_q;
        ready_d = '0;
        terr_d  = 1'b0;
        gap_d   = gap_q;
        to_d    = to_q;
        unique case (state_q)
            IDLE: begin
                to_d = '0;
                if (tx_txdone && win_found) begin
                    ready_d = win_oh;
                    byte_d  = req.req_data[win_idx*8 +: 8];
                    grant_d = win_oh;
                    rr_d    = win_idx;
                    lock_d  = ~req.req_last[win_idx];
                    state_d = START;
                end else if (lock_q && !req.req_valid[rr_q]) begin
                    if (to_hit) begin
                        terr_d  = 1'b1;
                        lock_d  = 1'b0;
                        grant_d = '0;
                    end else begin
                        to_d = to_inc;
                    end
                end
            end
            START: begin
                to_d    = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!tx_txdone) begin
                    to_d    = '0;
                    state_d = WAIT_DONE;
                end else if (to_hit) begin
                    to_d    = '0;
                    terr_d  = 1'b1;
                    lock_d  = 1'b0;
                    grant_d = '0;
                    state_d = IDLE;
                end else begin
                    to_d = to_inc;
                end
            end
            WAIT_DONE: begin
                if (tx_txdone) begin
                    to_d  = '0;
                    gap_d = '0;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                        if (!lock_q) grant_d = '0;
                    end else begin
                        state_d = GAP;
                    end
                end else if (to_hit) begin
                    to_d    = '0;
                    terr_d  = 1'b1;
                    lock_d  = 1'b0;
                    grant_d = '0;
                    state_d = IDLE;
                end else begin
                    to_d = to_inc;
                end
            end
            GAP: begin
                to_d = '0;
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    if (!lock_q) grant_d = '0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= PW'(N_REQ - 1);
            lock_q  <= 1'b0;
            grant_q <= '0;
            byte_q  <= 8'h00;
            ready_q <= '0;
            terr_q  <= 1'b0;
            gap_q   <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
            grant_q <= grant_d;
            byte_q  <= byte_d;
            ready_q <= ready_d;
            terr_q  <= terr_d;
            gap_q   <= gap_d;
            to_q    <= to_d;
        end
    end

    assign req.req_ready = ready_q;
    assign grant         = grant_q;
    assign tx_txbyte     = byte_q;
    assign tx_senddata   = (state_q == START);
    assign timeout_err   = terr_q;
    assign busy          = (state_q != IDLE) || lock_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural transmitter.
// Expected bytes come from a message-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int          N     = 4;
    localparam int          FRAME = 10;
    localparam logic [15:0] TO    = 16'd100;

    typedef struct packed {
        logic [2:0] id;
        logic [7:0] b;
    } exp_t;

    typedef struct packed {
        logic [7:0] b;
        logic       l;
    } item_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   grant;
    logic           busy;
    logic [7:0]     tx_txbyte;
    logic           tx_senddata;
    logic           tx_txdone = 1'b1;
    logic           timeout_err;

    exp_t  exp_q[$];
    item_t pq[N][$];
    int    checks = 0;
    int    passed = 0;
    int    to_count = 0;
    bit    stuck = 1'b0;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(
        .N_REQ(N),
        .GAP_CYCLES(2),
        .TO_W(16),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(bus.slave),
        .grant(grant),
        .busy(busy),
        .tx_txbyte(tx_txbyte),
        .tx_senddata(tx_senddata),
        .tx_txdone(tx_txdone),
        .timeout_err(timeout_err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act === want) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, want);
    endtask

    function automatic bit pq_empty();
        for (int i = 0; i < N; i++)
            if (pq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic put(input int p, input logic [7:0] b, input logic l);
        item_t it;
        it.b = b;
        it.l = l;
        pq[p].push_back(it);
    endtask

    task automatic expect_byte(input int p, input logic [7:0] b);
        exp_t e;
        e.id = 3'(p);
        e.b  = b;
        exp_q.push_back(e);
    endtask

    // Producers: hold the queue head until a ready pulse consumes it.
    initial begin
        logic [N-1:0]   v;
        logic [N-1:0]   l;
        logic [8*N-1:0] d;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        forever begin
            @(negedge clk);
            v = '0;
            l = '0;
            d = '0;
            for (int i = 0; i < N; i++) begin
                if (bus.req_ready[i] && pq[i].size() > 0)
                    void'(pq[i].pop_front());
                if (pq[i].size() > 0) begin
                    v[i] = 1'b1;
                    l[i] = pq[i][0].l;
                    d[i*8 +: 8] = pq[i][0].b;
                end
            end
            bus.req_valid = v;
            bus.req_last  = l;
            bus.req_data  = d;
        end
    end

    // Transmitter: txdone low for a frame after each accepted senddata.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (tx_txdone) begin
                if (tx_senddata && !stuck) begin
                    tx_txdone = 1'b0;
                    cnt = FRAME;
                end
            end else if (cnt == 0) begin
                tx_txdone = 1'b1;
            end else begin
                cnt--;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (bus.req_ready != '0) begin
                    chk("ready_onehot", 32'($onehot(bus.req_ready)), 1);
                    chk("ready_txdone", 32'(tx_txdone), 1);
                end
                if (tx_senddata) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_send", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_byte", 32'(tx_txbyte), 32'(e.b));
                        chk("grant_owner", 32'(grant), 32'(1) << e.id);
                    end
                end
                if (timeout_err) to_count++;
            end
        end
    end

    task automatic drain(input string nm, input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !busy && tx_txdone && pq_empty()) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, 32'(ok), 1);
    endtask

    task automatic wait_ready(input int p, input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (bus.req_ready[p]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_ready", 32'(ok), 1);
    endtask

    task automatic wait_terr(input int budget, output int el);
        el = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            if (timeout_err) begin
                el = c;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Message-level round robin: whole messages, nearest pending after last owner.
    task automatic random_phase();
        int   mlen[N][$];
        logic [7:0] mbytes[N][$];
        int   ptr;
        int   left;
        int   p;
        int   len;
        for (int i = 0; i < N; i++) begin
            int nm;
            nm = $urandom_range(0, 3);
            for (int m = 0; m < nm; m++) begin
                len = $urandom_range(1, 3);
                mlen[i].push_back(len);
                for (int j = 0; j < len; j++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    mbytes[i].push_back(b);
                    put(i, b, j == len - 1);
                end
            end
        end
        ptr = N - 1;
        left = 0;
        for (int i = 0; i < N; i++) left += mlen[i].size();
        while (left > 0) begin
            for (int k = 1; k <= N; k++) begin
                p = (ptr + k) % N;
                if (mlen[p].size() > 0) break;
            end
            len = mlen[p].pop_front();
            for (int j = 0; j < len; j++)
                expect_byte(p, mbytes[p].pop_front());
            ptr = p;
            left--;
        end
    endtask

    initial begin
        int el;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({grant, busy, tx_txbyte, tx_senddata,
                                  timeout_err, bus.req_ready}), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        expect_byte(0, 8'h41);
        put(0, 8'h41, 1'b1);
        @(posedge clk);
        #1;
        chk("single_ready", 32'(bus.req_ready), 32'h1);
        chk("single_byte", 32'(tx_txbyte), 32'h41);
        chk("single_send", 32'(tx_senddata), 1);
        chk("single_busy", 32'(busy), 1);
        drain("single_drain", 200);
        chk("single_grant_clear", 32'(grant), 0);

        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) begin
                put(i, 8'(8'h30 + i), 1'b1);
                expect_byte(i, 8'(8'h30 + i));
            end
        drain("contention_drain", 400);

        expect_byte(2, 8'h48);
        expect_byte(2, 8'h49);
        expect_byte(2, 8'h0A);
        expect_byte(1, 8'h52);
        put(2, 8'h48, 1'b0);
        put(2, 8'h49, 1'b0);
        put(2, 8'h0A, 1'b1);
        wait_ready(2, 20);
        put(1, 8'h52, 1'b1);
        drain("locked_drain", 400);
        chk("no_timeout_yet", 32'(to_count), 0);

        expect_byte(3, 8'h55);
        expect_byte(0, 8'h66);
        put(3, 8'h55, 1'b0);
        wait_ready(3, 20);
        put(0, 8'h66, 1'b1);
        wait_terr(400, el);
        chk("stall_delay", 32'(el >= int'(TO) + FRAME && el <= int'(TO) + FRAME + 8), 1);
        chk("stall_grant_clear", 32'(grant), 0);
        drain("stall_drain", 400);

        stuck = 1'b1;
        expect_byte(1, 8'h77);
        put(1, 8'h77, 1'b1);
        wait_ready(1, 20);
        wait_terr(400, el);
        chk("stuck_delay", 32'(el >= int'(TO) && el <= int'(TO) + 3), 1);
        chk("stuck_idle", 32'({grant, busy}), 0);
        stuck = 1'b0;
        drain("stuck_drain", 100);

        expect_byte(2, 8'h88);
        put(2, 8'h88, 1'b1);
        wait_ready(2, 20);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_outputs", 32'({grant, busy, tx_txbyte, tx_senddata,
                                     timeout_err, bus.req_ready}), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        expect_byte(0, 8'h90);
        expect_byte(1, 8'h91);
        expect_byte(3, 8'h93);
        put(3, 8'h93, 1'b1);
        put(0, 8'h90, 1'b1);
        put(1, 8'h91, 1'b1);
        drain("midreset_drain", 400);

        do_reset();
        random_phase();
        drain("random_drain", 3000);

        chk("sb_empty", exp_q.size(), 0);
        chk("timeout_count", 32'(to_count), 2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
